// File: rtl/frame_ingress_writer_pkg.sv
// Shared types and constants for the frame ingress writer: sideband entry
// layout, FSM state encoding and the AXI-stream source/sink bundles.
package frame_ingress_writer_pkg;
  localparam int DATA_W       = 16;
  localparam int SB_W         = 20;
  localparam int SB_VALID_BIT = 0;
  localparam int SB_TRUNC_BIT = 1;
  localparam int SB_PTR_LSB   = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DISCARD, S_REWIND, S_COMMIT
  } state_e;

  typedef struct packed {
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;
endpackage

// File: rtl/frame_ingress_writer_if.sv
// Ingress AXI-stream port: source bundle flows downstream, sink bundle
// carries tready back upstream.
interface frame_ingress_writer_if;
  import frame_ingress_writer_pkg::*;
  axis_d_source_t source;
  axis_d_sink_t   sink;
  modport master (output source, input sink);
  modport slave  (input source, output sink);
endinterface

// File: rtl/frame_ingress_writer_filter.sv
// ingress_header_filter: tests one header word of each frame against a
// masked value and counts dropped frames (saturating at 0xFFFF).
module ingress_header_filter
  import frame_ingress_writer_pkg::*;
#(
  parameter int CW              = 4,
  parameter int FILTER_WORD_IDX = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hs_i,
  input  logic [CW-1:0]     idx_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic [DATA_W-1:0] filter_value_i,
  input  logic [DATA_W-1:0] filter_mask_i,
  input  logic              drop_on_match_i,
  input  logic              rewind_i,
  output logic              drop_o,
  output logic [15:0]       drop_count_o
);
  logic        match;
  logic [15:0] cnt_q, cnt_d;

  assign match  = ((tdata_i ^ filter_value_i) & filter_mask_i) == '0;
  assign drop_o = hs_i & (idx_i == CW'(FILTER_WORD_IDX)) & (match == drop_on_match_i);

  // One count per rewind, held once it reaches all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (rewind_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign drop_count_o = cnt_q;
endmodule

// File: rtl/frame_ingress_writer.sv
// Frame ingress writer: streams AXI words into the frame buffer, commits a
// sideband end-pointer entry per frame and optionally drops frames on a
// header-word match. Optional feature macro: INGRESS_FILTER_EN.
module frame_ingress_writer
  import frame_ingress_writer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 11,
  parameter int MAX_FRAME_WORDS = 1024,
  parameter int FILTER_WORD_IDX = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_ingress_writer_if.slave ingress,
  output logic [DATA_W-1:0]     frame_wdata,
  output logic                  frame_wen,
  input  logic                  frame_full,
  input  logic [ADDR_WIDTH:0]   frame_wptr,
  output logic                  frame_wrst,
  output logic [ADDR_WIDTH:0]   frame_rst_wptr,
  output logic [SB_W-1:0]       sideband_wdata,
  output logic                  sideband_wen,
  input  logic                  sideband_full,
  output logic                  scan_payload,
  input  logic [DATA_W-1:0]     filter_value,
  input  logic [DATA_W-1:0]     filter_mask,
  input  logic                  filter_drop_on_match,
  output logic [15:0]           drop_count
);
  localparam int PW = ADDR_WIDTH + 1;
  // Counter must reach the filter word index even when it exceeds the frame cap.
  localparam int CTR_MAX = (MAX_FRAME_WORDS > FILTER_WORD_IDX) ? MAX_FRAME_WORDS : FILTER_WORD_IDX + 1;
  localparam int CW = $clog2(CTR_MAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   word_ctr_q, word_ctr_d, idx;
  logic [PW-1:0]   start_ptr_q, start_ptr_d;
  logic            trunc_q, trunc_d, tail_q, tail_d;
  logic            tready, hs, wr_phase, wr_hs, in_range, last, drop;

  assign wr_phase = (state_q == S_IDLE) | (state_q == S_RECV);
  // tready is forced low while reset is held so upstream never handshakes.
  assign tready   = reset & ((state_q == S_DISCARD) | (wr_phase & ~frame_full));
  assign ingress.sink.tready = tready;
  assign hs       = ingress.source.tvalid & tready;
  assign wr_hs    = hs & wr_phase;
  assign last     = ingress.source.tlast;
  // Index of the word on the bus; IDLE always means word 0 of a new frame.
  assign idx      = (state_q == S_IDLE) ? '0 : word_ctr_q;
  assign in_range = idx < CW'(MAX_FRAME_WORDS);

`ifdef INGRESS_FILTER_EN
  ingress_header_filter #(.CW(CW), .FILTER_WORD_IDX(FILTER_WORD_IDX)) u_filter (
    .clk(clk), .reset(reset), .hs_i(wr_hs), .idx_i(idx),
    .tdata_i(ingress.source.tdata), .filter_value_i(filter_value),
    .filter_mask_i(filter_mask), .drop_on_match_i(filter_drop_on_match),
    .rewind_i(state_q == S_REWIND), .drop_o(drop), .drop_count_o(drop_count)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{filter_value, filter_mask, filter_drop_on_match};
  assign drop       = 1'b0;
  assign drop_count = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RECV:
        if (wr_hs) begin
          if (drop)      state_d = S_REWIND;
          else if (last) state_d = S_COMMIT;
          else           state_d = S_RECV;
        end
      S_REWIND:  state_d = tail_q ? S_DISCARD : S_IDLE;
      S_DISCARD: if (hs && last) state_d = S_IDLE;
      S_COMMIT:  if (!sideband_full) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Per-frame bookkeeping: word count, start pointer, truncation, pending tail.
  always_comb begin
    word_ctr_d  = word_ctr_q;
    start_ptr_d = start_ptr_q;
    trunc_d     = trunc_q;
    tail_d      = tail_q;
    if (wr_hs) begin
      word_ctr_d = (idx < CW'(CTR_MAX)) ? idx + 1'b1 : idx;
      trunc_d    = ((state_q == S_IDLE) ? 1'b0 : trunc_q) | ~in_range;
      tail_d     = ~last;
      if (state_q == S_IDLE) start_ptr_d = frame_wptr;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      word_ctr_q  <= '0;
      start_ptr_q <= '0;
      trunc_q     <= 1'b0;
      tail_q      <= 1'b0;
    end else begin
      word_ctr_q  <= word_ctr_d;
      start_ptr_q <= start_ptr_d;
      trunc_q     <= trunc_d;
      tail_q      <= tail_d;
    end

  // FSM outputs: zero-cycle buffer write, rewind strobe, sideband commit.
  always_comb begin
    frame_wen      = wr_hs & in_range;
    frame_wdata    = frame_wen ? ingress.source.tdata : '0;
    frame_wrst     = state_q == S_REWIND;
    frame_rst_wptr = frame_wrst ? start_ptr_q : '0;
    sideband_wen   = (state_q == S_COMMIT) & ~sideband_full;
    sideband_wdata = '0;
    if (sideband_wen) begin
      sideband_wdata[SB_PTR_LSB +: PW] = frame_wptr;
      sideband_wdata[SB_TRUNC_BIT]     = trunc_q;
      sideband_wdata[SB_VALID_BIT]     = 1'b1;
    end
`ifdef INGRESS_FILTER_EN
    scan_payload = ((state_q == S_RECV) | (state_q == S_COMMIT)) & (word_ctr_q > CW'(FILTER_WORD_IDX));
`else
    scan_payload = (state_q == S_RECV) | (state_q == S_COMMIT);
`endif
  end
endmodule

// File: tb/tb_frame_ingress_writer.sv
// Directed bench for frame_ingress_writer with a behavioural frame-buffer
// write pointer; runs with MAX_FRAME_WORDS=8 so truncation is reachable.
module tb_frame_ingress_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] frame_wdata, filter_value, filter_mask, drop_count;
  logic        frame_wen, frame_full, frame_wrst, sideband_wen, sideband_full;
  logic        scan_payload, filter_drop_on_match;
  logic [11:0] frame_wptr, frame_rst_wptr;
  logic [19:0] sideband_wdata;

  frame_ingress_writer_if ing ();

  frame_ingress_writer #(.ADDR_WIDTH(11), .MAX_FRAME_WORDS(8), .FILTER_WORD_IDX(6)) dut (
    .clk(clk), .reset(reset), .ingress(ing),
    .frame_wdata(frame_wdata), .frame_wen(frame_wen), .frame_full(frame_full),
    .frame_wptr(frame_wptr), .frame_wrst(frame_wrst), .frame_rst_wptr(frame_rst_wptr),
    .sideband_wdata(sideband_wdata), .sideband_wen(sideband_wen), .sideband_full(sideband_full),
    .scan_payload(scan_payload), .filter_value(filter_value), .filter_mask(filter_mask),
    .filter_drop_on_match(filter_drop_on_match), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, stalls = 0;
  int wcnt = 0, sbcnt = 0, rwcnt = 0, scnt = 0;
  logic [15:0] wlog [256];
  logic [19:0] sblast;
  logic [11:0] rwlast;

  // Frame buffer write pointer, sharing the DUT reset.
  always @(posedge clk or negedge reset)
    if (!reset)          frame_wptr <= '0;
    else if (frame_wrst) frame_wptr <= frame_rst_wptr;
    else if (frame_wen)  frame_wptr <= frame_wptr + 12'd1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_wen) begin
      if (wcnt < 256) wlog[wcnt] <= frame_wdata;
      wcnt <= wcnt + 1;
    end
    if (sideband_wen) begin sbcnt <= sbcnt + 1; sblast <= sideband_wdata; end
    if (frame_wrst) begin rwcnt <= rwcnt + 1; rwlast <= frame_rst_wptr; end
    if (scan_payload) scnt <= scnt + 1;
  end

  task automatic send_word(input logic [15:0] d, input bit l);
    int t = 0;
    bit acc = 0;
    ing.source.tvalid = 1'b1; ing.source.tdata = d; ing.source.tlast = l;
    while (!acc && t < 40) begin
      @(negedge clk); acc = ing.sink.tready;
      if (!acc) stalls++;
      @(posedge clk); #1; t++;
    end
    if (!acc) begin total++; bad++; $display("FAIL hs_timeout data=%h got=no_ready want=ready", d); end
  endtask

  task automatic send_range(input logic [15:0] base, input logic [15:0] step, input int first, input int lastw, input int ntot);
    for (int i = first; i <= lastw; i++) send_word(16'(base + 16'(i) * step), i == ntot - 1);
  endtask

  task automatic end_frame();
    ing.source.tvalid = 1'b0; ing.source.tlast = 1'b0;
  endtask

  task automatic wait_sb(input int n);
    int t = 0;
    while (sbcnt < n && t < 40) begin @(posedge clk); #1; t++; end
    total++;
    if (sbcnt < n) begin bad++; $display("FAIL sb_wait got=%0d want=%0d", sbcnt, n); end
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_full = 0; sideband_full = 0;
    filter_value = 0; filter_mask = 0; filter_drop_on_match = 0;
    ing.source.tvalid = 1'b1; ing.source.tdata = 16'hABCD; ing.source.tlast = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({ing.sink.tready, frame_wen, frame_wrst, sideband_wen, scan_payload} !== 5'b0) begin
      bad++; $display("FAIL rst_strobes got=%b want=00000", {ing.sink.tready, frame_wen, frame_wrst, sideband_wen, scan_payload});
    end
    total++;
    if (drop_count !== 16'h0) begin bad++; $display("FAIL rst_dropcnt got=%h want=0000", drop_count); end
    total++;
    if ({frame_wdata, frame_rst_wptr, sideband_wdata} !== 48'h0) begin
      bad++; $display("FAIL rst_data got=%h/%h/%h want=0", frame_wdata, frame_rst_wptr, sideband_wdata);
    end
    end_frame();
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ing.sink.tready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ing.sink.tready); end
  endtask

  task automatic test_basic();
    int w0 = wcnt, s0 = sbcnt;
    bit ok = 1;
    filter_value = 16'h0; filter_mask = 16'h0; filter_drop_on_match = 1'b1;
    send_range(16'h1111, 16'h1111, 0, 3, 4); end_frame();
    wait_sb(s0 + 1);
    total++;
    if (wcnt - w0 != 4) begin bad++; $display("FAIL basic_wcnt got=%0d want=4", wcnt - w0); end
    for (int i = 0; i < 4; i++) if (wlog[w0 + i] !== 16'(16'h1111 * (i + 1))) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_data got=%h.. want=1111..4444", wlog[w0]); end
    total++;
    if (sblast !== 20'h00011) begin bad++; $display("FAIL basic_sb got=%h want=00011", sblast); end
  endtask

  task automatic test_filter();
    int w0 = wcnt, s0 = sbcnt, r0 = rwcnt, c0 = scnt;
    logic [11:0] p0 = frame_wptr;
    filter_value = 16'h0800; filter_mask = 16'hFFFF; filter_drop_on_match = 1'b1;
    send_range(16'h0200, 16'h0100, 0, 9, 10); end_frame();
`ifdef INGRESS_FILTER_EN
    repeat (3) @(posedge clk); #1;
    total++;
    if (rwcnt - r0 != 1 || rwlast !== p0) begin
      bad++; $display("FAIL flt_rewind got=%0d/%h want=1/%h", rwcnt - r0, rwlast, p0);
    end
    total++;
    if (sbcnt != s0) begin bad++; $display("FAIL flt_nosb got=%0d want=0", sbcnt - s0); end
    total++;
    if (drop_count !== 16'd1) begin bad++; $display("FAIL flt_dropcnt got=%0d want=1", drop_count); end
    total++;
    if (scnt != c0) begin bad++; $display("FAIL flt_scan got=%0d want=0", scnt - c0); end
    total++;
    if (frame_wptr !== p0 || wcnt - w0 != 7) begin
      bad++; $display("FAIL flt_wptr got=%h/%0d want=%h/7", frame_wptr, wcnt - w0, p0);
    end
`else
    wait_sb(s0 + 1);
    total++;
    if (sblast !== 20'({12'(p0 + 12'd8), 2'b11})) begin
      bad++; $display("FAIL nof_sb got=%h want=%h", sblast, 20'({12'(p0 + 12'd8), 2'b11}));
    end
    total++;
    if (drop_count !== 16'd0 || rwcnt != r0 || wcnt - w0 != 8) begin
      bad++; $display("FAIL nof_nodrop got=%0d/%0d/%0d want=0/0/8", drop_count, rwcnt - r0, wcnt - w0);
    end
`endif
  endtask

  task automatic test_trunc();
    int w0 = wcnt, s0 = sbcnt, c0 = scnt;
    logic [11:0] p0 = frame_wptr;
    filter_mask = 16'h0; filter_drop_on_match = 1'b0;
    stalls = 0;
    send_range(16'h5000, 16'h0001, 0, 11, 12); end_frame();
    wait_sb(s0 + 1);
    total++;
    if (wcnt - w0 != 8 || wlog[w0 + 7] !== 16'h5007) begin
      bad++; $display("FAIL trunc_writes got=%0d/%h want=8/5007", wcnt - w0, wlog[w0 + 7]);
    end
    total++;
    if (stalls != 0) begin bad++; $display("FAIL trunc_ready got=%0d want=0 stalls", stalls); end
    total++;
    if (sblast !== 20'({12'(p0 + 12'd8), 2'b11})) begin
      bad++; $display("FAIL trunc_sb got=%h want=%h", sblast, 20'({12'(p0 + 12'd8), 2'b11}));
    end
    total++;
    if (scnt == c0) begin bad++; $display("FAIL trunc_scan got=0 want=nonzero"); end
  endtask

  task automatic test_sb_full();
    int s0 = sbcnt;
    logic [11:0] p0 = frame_wptr;
    sideband_full = 1'b1;
    send_range(16'h6000, 16'h0001, 0, 2, 3); end_frame();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ing.sink.tready !== 1'b0 || sideband_wen !== 1'b0) begin
        bad++; $display("FAIL sbf_hold cyc=%0d got=%b%b want=00", i, ing.sink.tready, sideband_wen);
      end
      @(posedge clk); #1;
    end
    sideband_full = 1'b0;
    @(negedge clk);
    total++;
    if (sideband_wen !== 1'b1 || sideband_wdata !== 20'({12'(p0 + 12'd3), 2'b01})) begin
      bad++; $display("FAIL sbf_release got=%b/%h want=1/%h", sideband_wen, sideband_wdata, 20'({12'(p0 + 12'd3), 2'b01}));
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (sbcnt - s0 != 1) begin bad++; $display("FAIL sbf_single got=%0d want=1", sbcnt - s0); end
  endtask

  task automatic test_back_to_back();
    int w0 = wcnt, s0 = sbcnt;
    logic [11:0] p0 = frame_wptr;
    stalls = 0;
    send_range(16'hA000, 16'h0001, 0, 1, 2);
    send_range(16'hB000, 16'h0001, 0, 1, 2); end_frame();
    wait_sb(s0 + 2);
    total++;
    if (stalls != 1) begin bad++; $display("FAIL b2b_stalls got=%0d want=1", stalls); end
    total++;
    if (wcnt - w0 != 4 || wlog[w0 + 2] !== 16'hB000 || sblast !== 20'({12'(p0 + 12'd4), 2'b01})) begin
      bad++; $display("FAIL b2b_commit got=%0d/%h/%h want=4/b000/%h", wcnt - w0, wlog[w0 + 2], sblast, 20'({12'(p0 + 12'd4), 2'b01}));
    end
  endtask

  task automatic test_ffull();
    int w0 = wcnt, s0 = sbcnt, r0 = rwcnt;
    logic [11:0] p0 = frame_wptr;
    bit ok = 1;
    send_range(16'h7000, 16'h0001, 0, 2, 6);
    frame_full = 1'b1; ing.source.tdata = 16'h7003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ing.sink.tready !== 1'b0 || frame_wen !== 1'b0) begin
        bad++; $display("FAIL ffull_stall cyc=%0d got=%b%b want=00", i, ing.sink.tready, frame_wen);
      end
      @(posedge clk); #1;
    end
    frame_full = 1'b0;
    send_range(16'h7000, 16'h0001, 3, 5, 6); end_frame();
    wait_sb(s0 + 1);
    for (int i = 0; i < 6; i++) if (wlog[w0 + i] !== 16'(16'h7000 + i)) ok = 0;
    total++;
    if (wcnt - w0 != 6 || !ok) begin bad++; $display("FAIL ffull_data got=%0d words want=6 intact", wcnt - w0); end
    total++;
    if (sblast !== 20'({12'(p0 + 12'd6), 2'b01}) || rwcnt != r0) begin
      bad++; $display("FAIL ffull_sb got=%h/%0d want=%h/0", sblast, rwcnt - r0, 20'({12'(p0 + 12'd6), 2'b01}));
    end
  endtask

  task automatic test_reset_mid();
    int s0 = sbcnt, r0 = rwcnt;
    send_range(16'h8000, 16'h0001, 0, 2, 10);
    reset = 1'b0; #1;
    total++;
    if ({ing.sink.tready, frame_wen, frame_wrst, sideband_wen, scan_payload} !== 5'b0) begin
      bad++; $display("FAIL rmid_async got=%b want=00000", {ing.sink.tready, frame_wen, frame_wrst, sideband_wen, scan_payload});
    end
    end_frame();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (sbcnt != s0) begin bad++; $display("FAIL rmid_nosb got=%0d want=0", sbcnt - s0); end
    send_range(16'h9000, 16'h0001, 0, 1, 2); end_frame();
    wait_sb(s0 + 1);
    total++;
    if (sblast !== 20'h00009 || rwcnt != r0) begin
      bad++; $display("FAIL rmid_next got=%h/%0d want=00009/0", sblast, rwcnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_trunc();
    test_sb_full();
    test_back_to_back();
    test_ffull();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_ingress_writer.md
# frame_ingress_writer

Ingress stage of the packet filter. Accepts 16-bit AXI-stream words from the ingress port, writes them into the frame buffer, and applies an optional header-word match filter. On each accepted frame's last word it commits one sideband entry marking the frame's end pointer. It drives `scan_payload` so that the downstream switch requester can begin cut-through reads of a frame before the frame is committed.

## Interface
- `ADDR_WIDTH`, 11: frame buffer address width; pointers are `ADDR_WIDTH+1` bits. Must be ≤17.
- `MAX_FRAME_WORDS`, 1024: maximum number of words stored per frame.
- `FILTER_WORD_IDX`, 6: 0-based index of the word tested by the filter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `ingress_source` in `axis_d_source_t`: upstream tvalid/tdata[15:0]/tlast.
- `ingress_sink` out `axis_d_sink_t`: tready to upstream.
- `frame_wdata` out 16: word to the frame buffer.
- `frame_wen` out 1: frame buffer write strobe.
- `frame_full` in 1: frame buffer full.
- `frame_wptr` in `ADDR_WIDTH+1`: current frame buffer write pointer.
- `frame_wrst` out 1: one-cycle rewind strobe for the write pointer.
- `frame_rst_wptr` out `ADDR_WIDTH+1`: rewind target pointer.
- `sideband_wdata` out 20: sideband entry.
- `sideband_wen` out 1: sideband write strobe.
- `sideband_full` in 1: sideband FIFO full.
- `scan_payload` out 1: an uncommitted, non-droppable frame is being written.
- `filter_value` in 16, `filter_mask` in 16, `filter_drop_on_match` in 1: filter configuration.
- `drop_count` out 16: count of filtered frames; saturates at 0xFFFF.

## Operation
States: IDLE, RECV, DISCARD, REWIND, COMMIT.

- **Frame start.** On the first accepted word, capture `start_ptr <= frame_wptr`, clear `word_ctr`, and write the word.
  - Single-word frame (tlast on the first word): go to COMMIT.
  - Otherwise: go to RECV.
- **Write rule.** In IDLE/RECV, every handshake (`tvalid & tready`) writes `tdata`, provided `word_ctr < MAX_FRAME_WORDS`.
- **Truncation.** Once `word_ctr` reaches `MAX_FRAME_WORDS`, further words are accepted but not written, and the frame's truncation flag is set.
- **Filter.** Evaluated on word `FILTER_WORD_IDX`: `match = ((tdata ^ filter_value) & filter_mask) == 0`. The frame is dropped when `match == filter_drop_on_match`.
  - Drop, tlast not yet seen: go to REWIND, then DISCARD.
  - Drop, tlast on this word: go to REWIND, then IDLE.
  - Frames shorter than `FILTER_WORD_IDX+1` words are never dropped.
- **REWIND.** One cycle: `frame_wrst = 1`, `frame_rst_wptr = start_ptr`, `drop_count` increments (saturating).
- **DISCARD.** `tready = 1`, no writes; go to IDLE after the tlast handshake.
- **COMMIT.** Stays here while `sideband_full`. When `~sideband_full`:
  - pulse `sideband_wen` with:
    - `[ADDR_WIDTH+2:2]` = `frame_wptr`, the end pointer, one past the last word;
    - `[1]` = truncation flag;
    - `[0]` = 1;
    - all other bits 0;
  - then go to IDLE.
- **scan_payload.** High in RECV/COMMIT once `word_ctr > FILTER_WORD_IDX`, meaning the frame can no longer be dropped. Low otherwise. Never high in DISCARD or REWIND.
- **Backpressure.** `tready = ~frame_full` in IDLE/RECV; `1` in DISCARD; `0` in REWIND/COMMIT.

## Timing
- Reset values: state IDLE; `tready`, `frame_wen`, `frame_wrst`, `sideband_wen`, `scan_payload` = 0; `drop_count`, `frame_wdata`, `frame_rst_wptr`, `sideband_wdata` = 0.
- `frame_wen` and `frame_wdata` are combinational from the handshake: zero-cycle write.
- `sideband_wen` asserts no earlier than 1 cycle after the tlast handshake.
- Back-to-back frames: the first word of the next frame is accepted in the cycle after the COMMIT exit (IDLE).
- If `frame_full` rises mid-frame, `tready` drops in the same cycle. The frame is never rewound for this.
- Reset mid-frame: the partial frame is abandoned. No sideband entry is written and the frame buffer is not rewound; the frame buffer shares the same reset.

## Configuration
- `INGRESS_FILTER_EN`
  - Defined: filter compare, REWIND/DISCARD paths, and `drop_count` logic are present.
  - Undefined: no frame is ever dropped; `drop_count` is tied to 0; filter inputs are ignored; `scan_payload` asserts from the first written word.

## Structure
- Shared package: sideband field offsets (`SB_VALID_BIT = 0`, `SB_TRUNC_BIT = 1`, `SB_PTR_LSB = 2`), the state enum, `axis_d_source_t` / `axis_d_sink_t`.
- One sub-module: `ingress_header_filter`. It holds the word-index compare, the match logic, and the saturating drop counter.

## Test plan
- 4-word frame `0x1111..0x4444`, filter off, `frame_wptr` starting at 0 → 4 writes, then sideband entry `0x00011` (ptr=4, valid).
- 10-word frame, word 6 = `0x0800`, value `0x0800`, mask `0xFFFF`, drop_on_match=1 → REWIND with `frame_rst_wptr` = start, no sideband write, `drop_count` = 1, `scan_payload` never high.
- `MAX_FRAME_WORDS = 8`, 12-word frame → 8 writes, `tready` held high, sideband bit1 = 1, pointer = start + 8.
- `sideband_full` held for 5 cycles at tlast → remain in COMMIT, `tready` = 0, single `sideband_wen` after release.
- `frame_full` pulsed for 3 cycles mid-frame → `tready` = 0 for those cycles, no word lost, frame committed intact.
- `reset` asserted low during RECV → all outputs 0 asynchronously; next frame commits correctly.
